// File: rtl/d_ff.sv
// Parameterised D-type register with a synchronous load enable,
// an asynchronous active-high clear, and a complemented output.
module d_ff #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  // Clear is in the sensitivity list so it acts without waiting for a clock
  // edge, and it is tested first so it also wins over a coincident capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_d_ff.sv
// Scoreboard bench for d_ff: a 1-bit instance and an 8-bit instance (reset
// value A5) share clk/clr/en. The expected value after each edge is queued.
module tb_d_ff;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic       q1_n;
  logic [7:0] q8;
  logic [7:0] q8_n;

  typedef struct packed {
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic       model_q1;
  logic [7:0] model_q8;
  logic       stim_done = 1'b0;

  d_ff #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .clr(clr), .d(d1), .en(en), .q(q1), .q_n(q1_n)
  );

  d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
    .clk(clk), .clr(clr), .d(d8), .en(en), .q(q8), .q_n(q8_n)
  );

  // Rising edges at t=50, 150, 250, ...
  always #50 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h at t=%0t", name, actual, required, $time);
    end
  endtask

  task automatic check_now(input string name);
    check_output({name, "_q1"},   {7'b0, q1},   {7'b0, model_q1});
    check_output({name, "_q1_n"}, {7'b0, q1_n}, {7'b0, ~model_q1});
    check_output({name, "_q8"},   q8,           model_q8);
    check_output({name, "_q8_n"}, q8_n,         ~model_q8);
  endtask

  // One clock cycle of stimulus, driven from the falling edge. d may be
  // scrambled several times before settling on the value the edge should see.
  task automatic apply_stimulus(input logic c, input logic e, input logic dd1,
                                input logic [7:0] dd8, input int toggles);
    @(negedge clk);
    clr = c;
    en  = e;
    if (c) begin
      model_q1 = 1'b0;
      model_q8 = RV8;
    end
    #1;
    check_now("between_edges");
    for (int i = 0; i < toggles; i++) begin
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      #7;
    end
    d1 = dd1;
    d8 = dd8;
    if (c) begin
      model_q1 = 1'b0;
      model_q8 = RV8;
    end else if (e) begin
      model_q1 = dd1;
      model_q8 = dd8;
    end
    exp_q.push_back('{q1: model_q1, q8: model_q8});
  endtask

  // Raise clr 20 units after a rising edge and expect q to react at once.
  task automatic async_clear();
    @(posedge clk);
    #20;
    clr      = 1'b1;
    model_q1 = 1'b0;
    model_q8 = RV8;
    #1;
    check_now("async_clear");
  endtask

  // Monitor: the outputs are presented every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t ex;
        ex = exp_q.pop_front();
        check_output("edge_q1",   {7'b0, q1},   {7'b0, ex.q1});
        check_output("edge_q1_n", {7'b0, q1_n}, {7'b0, ~ex.q1});
        check_output("edge_q8",   q8,           ex.q8);
        check_output("edge_q8_n", q8_n,         ~ex.q8);
      end
    end
  end

  initial begin
    clr = 1'b0;
    en  = 1'b0;
    d1  = 1'b0;
    d8  = 8'h00;
    #1;
    clr      = 1'b1;
    model_q1 = 1'b0;
    model_q8 = RV8;
    #1;
    check_now("reset");

    // Enabled capture, then hold with en low.
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h3C, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h5A, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'hC3, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'hFF, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h3C, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'hFF, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h81, 0);

    // Mid-cycle clear, held over edges with en=1, then released between edges.
    async_clear();
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h77, 0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h66, 0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h55, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h12, 0);

    // d toggling between edges.
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h9E, 5);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h01, 4);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 3);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        async_clear();
      end
      apply_stimulus(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                     8'($urandom), int'($urandom_range(0, 4)));
    end
    stim_done = 1'b1;
  end

  // Bounded end of run: drain the scoreboard and report.
  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    disable fork;
    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: actual=%0d pending (done=%0b) required=0 pending", exp_q.size(), stim_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_ff.md
Name: d_ff

Overview:
Single-clock, edge-triggered D-type storage element with a synchronous load enable and an asynchronous active-high clear. It is the basic state bit used by registers, counters and pipeline stages. It is parameterised in width so the same block serves as a 1-bit flop or a multi-bit register. It also provides a complemented output.

Parameters:
WIDTH, 1, data width in bits of d, q and q_n.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q when clr is asserted.

Ports:
clk  input  1  clock; all capture happens on the rising edge.
clr  input  1  asynchronous active-high clear/reset.
d  input  WIDTH  data to capture.
en  input  1  synchronous load enable, active-high.
q  output  WIDTH  registered data.
q_n  output  WIDTH  bitwise complement of q; may be left unconnected.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (clr).
- Clear:
  - clr rising drives q to RESET_VALUE immediately, with no wait for a clock edge.
  - While clr is high, q holds RESET_VALUE regardless of clk, en or d.
  - clr has priority over en at any clock edge.
  - q_n equals ~RESET_VALUE during clear.
- Release: clr falling does not change q. The first capture after release occurs on the next rising clk edge with en=1.
- Capture: on each rising clk edge with clr=0 and en=1, q takes the value of d sampled at that edge. Latency is 1 edge, so q updates just after the edge.
- Hold: on a rising clk edge with clr=0 and en=0, q keeps its previous value. Changes on d are ignored.
- Between edges, q is stable. Changes on d or en between edges have no effect on q.
- q_n is continuously ~q, combinational from the register with no extra register stage.
- Power-up: q is undefined until the first clr assertion or the first enabled capture. Systems must assert clr before relying on q.
- Simultaneous events:
  - d changing on the same edge: the pre-edge value is captured (standard setup semantics).
  - clr asserted at the same instant as a clk edge: the clear wins.
- Width: all WIDTH bits share en and clr. No per-bit enables, and no truncation or extension of d.

Test Plan:
The clock runs with a 100-unit period, rising at t=50, 150, 250, ... WIDTH=1 and RESET_VALUE=0 unless noted.
- Enabled capture: d=1, en=1, clr=0 at edge t=50 -> q=1, q_n=0. d=0 at edge t=150 -> q=0. d=1 at edge t=250 -> q=1.
- Hold: with q=1, set en=0, d=0 across edge t=350 -> q stays 1. Then en=1, d=0 at t=450 -> q=0. Then en=0, d=1 at t=550 -> q stays 0.
- Asynchronous clear mid-cycle: en=1, d=1 at edge t=650 -> q=1. Raise clr at t=670, between edges -> q=0 at t=670 without any clk edge. At edge t=750 with clr=1, en=1, d=1 -> q remains 0.
- Clear priority and release: hold clr=1 with en=1, d=1 over several edges -> q=0. Drop clr between edges -> q stays 0 until the next edge, then becomes 1.
- d toggling between edges: en=1, toggle d several times between two edges -> q changes only at the edge, to the value of d at that edge.
- Parameterised instance: WIDTH=8, RESET_VALUE=8'hA5.
  - clr pulse -> q=8'hA5, q_n=8'h5A.
  - en=1, d=8'h3C at an edge -> q=8'h3C.
  - en=0, d=8'hFF at the next edge -> q stays 8'h3C.
